// File: rtl/regfile_read_ctrl.sv
// Read-port sequencer for the 16-entry register file: drives one-hot read enables,
// captures both bitlines and returns operands over valid/ready. Define REGFILE_BYPASS_EN for write forwarding.
module regfile_read_ctrl #(
   parameter int unsigned WIDTH  = 16,
   parameter int unsigned ADDR_W = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       req_valid,
   output logic                       req_ready,
   input  logic [ADDR_W-1:0]          req_rs1,
   input  logic [ADDR_W-1:0]          req_rs2,
   output logic [(1 << ADDR_W)-1:0]   ReadEnable1,
   output logic [(1 << ADDR_W)-1:0]   ReadEnable2,
   input  logic [WIDTH-1:0]           Bitline1,
   input  logic [WIDTH-1:0]           Bitline2,
   input  logic                       wr_en,
   input  logic [ADDR_W-1:0]          wr_reg,
   input  logic [WIDTH-1:0]           wr_data,
   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output logic [WIDTH-1:0]           rsp_data1,
   output logic [WIDTH-1:0]           rsp_data2
);

   localparam int unsigned NREGS = 1 << ADDR_W;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_DRIVE = 2'd1;
   localparam logic [1:0] S_HOLD  = 2'd2;

   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] rs1_q, rs1_d;
   logic [ADDR_W-1:0] rs2_q, rs2_d;
   logic [WIDTH-1:0]  data1_q, data1_d;
   logic [WIDTH-1:0]  data2_q, data2_d;
   logic [NREGS-1:0]  en1_q, en1_d;
   logic [NREGS-1:0]  en2_q, en2_d;
   logic              ready_q, ready_d;
   logic              valid_q, valid_d;
   logic              hit1, hit2;

   // Register 0 is hardwired zero, so it never gets an enable bit.
   function automatic logic [NREGS-1:0] id_to_enable(input logic [ADDR_W-1:0] id);
      id_to_enable = '0;
      if (id != '0) begin
         id_to_enable[id] = 1'b1;
      end
   endfunction

`ifdef REGFILE_BYPASS_EN
   assign hit1 = wr_en && (wr_reg == rs1_q) && (rs1_q != '0);
   assign hit2 = wr_en && (wr_reg == rs2_q) && (rs2_q != '0);
`else
   logic unused_wr;
   assign hit1      = 1'b0;
   assign hit2      = 1'b0;
   assign unused_wr = ^{wr_en, wr_reg, wr_data};
`endif

   // Next-state, operand capture and registered-output decode.
   always_comb begin
      state_d = state_q;
      rs1_d   = rs1_q;
      rs2_d   = rs2_q;
      data1_d = data1_q;
      data2_d = data2_q;
      ready_d = 1'b0;
      valid_d = 1'b0;
      en1_d   = '0;
      en2_d   = '0;

      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               state_d = S_DRIVE;
               rs1_d   = req_rs1;
               rs2_d   = req_rs2;
            end
         end
         S_DRIVE: begin
            state_d = S_HOLD;
            data1_d = (rs1_q == '0) ? '0 : (hit1 ? wr_data : Bitline1);
            data2_d = (rs2_q == '0) ? '0 : (hit2 ? wr_data : Bitline2);
         end
         S_HOLD: begin
            // A handshake in the same cycle as a forwarded write wins; the update is dropped.
            if (rsp_ready) begin
               state_d = S_IDLE;
            end else begin
               if (hit1) data1_d = wr_data;
               if (hit2) data2_d = wr_data;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      ready_d = (state_d == S_IDLE);
      valid_d = (state_d == S_HOLD);
      if (state_d == S_DRIVE) begin
         en1_d = id_to_enable(rs1_d);
         en2_d = id_to_enable(rs2_d);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         rs1_q   <= '0;
         rs2_q   <= '0;
         data1_q <= '0;
         data2_q <= '0;
         en1_q   <= '0;
         en2_q   <= '0;
         ready_q <= 1'b1;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         rs1_q   <= rs1_d;
         rs2_q   <= rs2_d;
         data1_q <= data1_d;
         data2_q <= data2_d;
         en1_q   <= en1_d;
         en2_q   <= en2_d;
         ready_q <= ready_d;
         valid_q <= valid_d;
      end
   end

   assign req_ready   = ready_q;
   assign rsp_valid   = valid_q;
   assign ReadEnable1 = en1_q;
   assign ReadEnable2 = en2_q;
   assign rsp_data1   = data1_q;
   assign rsp_data2   = data2_q;

endmodule

// File: tb/tb_regfile_read_ctrl.sv
// Self-checking bench for regfile_read_ctrl: vector table, directed corner sequences
// and a randomized transaction loop against a behavioural register-array model.
module tb_regfile_read_ctrl;

   localparam int unsigned NREGS = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready;
   logic [3:0]  req_rs1, req_rs2;
   logic [15:0] ReadEnable1, ReadEnable2;
   logic [15:0] Bitline1, Bitline2;
   logic        wr_en;
   logic [3:0]  wr_reg;
   logic [15:0] wr_data;
   logic        rsp_valid, rsp_ready;
   logic [15:0] rsp_data1, rsp_data2;

   int checks = 0;
   int errors = 0;

   logic [15:0] arr [NREGS];

   always #5 clk = ~clk;

   regfile_read_ctrl #(.WIDTH(16), .ADDR_W(4)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_rs1(req_rs1), .req_rs2(req_rs2),
      .ReadEnable1(ReadEnable1), .ReadEnable2(ReadEnable2),
      .Bitline1(Bitline1), .Bitline2(Bitline2),
      .wr_en(wr_en), .wr_reg(wr_reg), .wr_data(wr_data),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data1(rsp_data1), .rsp_data2(rsp_data2)
   );

   // Register array model: writes land at the clock edge.
   always_ff @(posedge clk) begin
      if (wr_en) arr[wr_reg] <= wr_data;
   end

   // Undriven bitlines float to a recognisable garbage value.
   always_comb begin
      Bitline1 = '0;
      Bitline2 = '0;
      for (int i = 0; i < NREGS; i++) begin
         if (ReadEnable1[i]) Bitline1 = Bitline1 | arr[i];
         if (ReadEnable2[i]) Bitline2 = Bitline2 | arr[i];
      end
      if (ReadEnable1 == '0) Bitline1 = 16'hDEAD;
      if (ReadEnable2 == '0) Bitline2 = 16'hDEAD;
   end

   typedef struct {
      logic [3:0]  rs1;
      logic [3:0]  rs2;
      logic [15:0] en1;
      logic [15:0] en2;
      logic [15:0] d1;
      logic [15:0] d2;
   } vec_t;

   vec_t vecs [6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] exp_enable(input logic [3:0] id);
      return (id == 4'd0) ? 16'h0000 : (16'h0001 << id);
   endfunction

   function automatic logic bypass_on();
`ifdef REGFILE_BYPASS_EN
      return 1'b1;
`else
      return 1'b0;
`endif
   endfunction

   task automatic write_reg(input logic [3:0] r, input logic [15:0] d);
      wr_en = 1'b1; wr_reg = r; wr_data = d;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   // Present a request in an IDLE cycle; returns at the DRIVE-cycle negedge.
   task automatic issue(input logic [3:0] a, input logic [3:0] b);
      req_valid = 1'b1; req_rs1 = a; req_rs2 = b;
      check("req_ready_idle", 32'(req_ready), 32'd1);
      @(negedge clk);
      req_valid = 1'b0;
      check("req_ready_drive", 32'(req_ready), 32'd0);
      check("rsp_valid_drive", 32'(rsp_valid), 32'd0);
   endtask

   task automatic rand_write(input logic [3:0] a, input logic [3:0] b);
      wr_en   = 1'($urandom_range(0, 1));
      wr_data = 16'($urandom);
      case ($urandom_range(0, 3))
         0:       wr_reg = a;
         1:       wr_reg = b;
         default: wr_reg = 4'($urandom);
      endcase
   endtask

   initial begin
      logic [15:0] e1, e2;
      logic        rdy;

      rst = 1'b1; req_valid = 1'b0; req_rs1 = '0; req_rs2 = '0;
      wr_en = 1'b0; wr_reg = '0; wr_data = '0; rsp_ready = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_req_ready", 32'(req_ready), 32'd1);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_en1", 32'(ReadEnable1), 32'd0);
      check("rst_en2", 32'(ReadEnable2), 32'd0);
      check("rst_data1", 32'(rsp_data1), 32'd0);
      check("rst_data2", 32'(rsp_data2), 32'd0);
      rst = 1'b0;

      write_reg(4'd3, 16'h1234);  write_reg(4'd7, 16'hBEEF);
      write_reg(4'd5, 16'h00FF);  write_reg(4'd2, 16'h1111);
      write_reg(4'd4, 16'hAAAA);  write_reg(4'd15, 16'hF00F);
      write_reg(4'd1, 16'h0101);

      vecs[0] = '{4'd3,  4'd7, 16'h0008, 16'h0080, 16'h1234, 16'hBEEF};
      vecs[1] = '{4'd0,  4'd5, 16'h0000, 16'h0020, 16'h0000, 16'h00FF};
      vecs[2] = '{4'd2,  4'd2, 16'h0004, 16'h0004, 16'h1111, 16'h1111};
      vecs[3] = '{4'd4,  4'd0, 16'h0010, 16'h0000, 16'hAAAA, 16'h0000};
      vecs[4] = '{4'd15, 4'd1, 16'h8000, 16'h0002, 16'hF00F, 16'h0101};
      vecs[5] = '{4'd0,  4'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0000};

      // Table: accept in T, enables in T+1, response in T+2, back-to-back.
      for (int i = 0; i < 6; i++) begin
         issue(vecs[i].rs1, vecs[i].rs2);
         check("tbl_en1", 32'(ReadEnable1), 32'(vecs[i].en1));
         check("tbl_en2", 32'(ReadEnable2), 32'(vecs[i].en2));
         @(negedge clk);
         check("tbl_valid", 32'(rsp_valid), 32'd1);
         check("tbl_en_off", 32'({ReadEnable1, ReadEnable2}), 32'd0);
         check("tbl_data1", 32'(rsp_data1), 32'(vecs[i].d1));
         check("tbl_data2", 32'(rsp_data2), 32'(vecs[i].d2));
         rsp_ready = 1'b1;
         @(negedge clk);
         rsp_ready = 1'b0;
         check("tbl_valid_drop", 32'(rsp_valid), 32'd0);
         check("tbl_ready_back", 32'(req_ready), 32'd1);
      end

      // Consumer stalls for 4 cycles: data and backpressure stay put.
      issue(4'd3, 4'd7);
      @(negedge clk);
      req_valid = 1'b1; req_rs1 = 4'd5; req_rs2 = 4'd5;
      for (int i = 0; i < 4; i++) begin
         check("stall_ready", 32'(req_ready), 32'd0);
         check("stall_valid", 32'(rsp_valid), 32'd1);
         check("stall_data", 32'({rsp_data1, rsp_data2}), 32'h1234BEEF);
         @(negedge clk);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      check("stall_release", 32'(req_ready), 32'd1);
      issue(4'd5, 4'd3);
      check("stall_next_en", 32'({ReadEnable1, ReadEnable2}), 32'h00200008);
      @(negedge clk);
      check("stall_next_data", 32'({rsp_data1, rsp_data2}), 32'h00FF1234);
      rsp_ready = 1'b1; @(negedge clk); rsp_ready = 1'b0;

      // Write to the selected register during DRIVE.
      issue(4'd2, 4'd2);
      wr_en = 1'b1; wr_reg = 4'd2; wr_data = 16'h2222;
      @(negedge clk);
      wr_en = 1'b0;
      e1 = bypass_on() ? 16'h2222 : 16'h1111;
      check("drv_fwd_data1", 32'(rsp_data1), 32'(e1));
      check("drv_fwd_data2", 32'(rsp_data2), 32'(e1));
      rsp_ready = 1'b1; @(negedge clk); rsp_ready = 1'b0;

      // Writes during HOLD; R0 writes never forward; handshake beats an update.
      issue(4'd4, 4'd0);
      @(negedge clk);
      check("hold_data1_init", 32'(rsp_data1), 32'h0000AAAA);
      wr_en = 1'b1; wr_reg = 4'd4; wr_data = 16'h5555;
      @(negedge clk);
      wr_en = 1'b0;
      e1 = bypass_on() ? 16'h5555 : 16'hAAAA;
      check("hold_fwd_data1", 32'(rsp_data1), 32'(e1));
      wr_en = 1'b1; wr_reg = 4'd0; wr_data = 16'h9999;
      @(negedge clk);
      wr_en = 1'b0;
      check("hold_r0_data1", 32'(rsp_data1), 32'(e1));
      check("hold_r0_data2", 32'(rsp_data2), 32'd0);
      rsp_ready = 1'b1; wr_en = 1'b1; wr_reg = 4'd4; wr_data = 16'h7777;
      @(negedge clk);
      rsp_ready = 1'b0; wr_en = 1'b0;
      check("hold_hs_valid", 32'(rsp_valid), 32'd0);
      check("hold_hs_ready", 32'(req_ready), 32'd1);

      // Reset in DRIVE drops the request.
      issue(4'd3, 4'd7);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rstd_en", 32'({ReadEnable1, ReadEnable2}), 32'd0);
      check("rstd_valid", 32'(rsp_valid), 32'd0);
      check("rstd_ready", 32'(req_ready), 32'd1);
      check("rstd_data", 32'({rsp_data1, rsp_data2}), 32'd0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("rstd_no_rsp", 32'(rsp_valid), 32'd0);
      end

      // Randomized transactions against the array model.
      for (int t = 0; t < 150; t++) begin
         logic [3:0] a, b;
         a = 4'($urandom);
         b = ($urandom_range(0, 3) == 0) ? a : 4'($urandom);
         for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
            rand_write(a, b);
            @(negedge clk);
         end
         rand_write(a, b);
         issue(a, b);
         e1 = (a == 4'd0) ? 16'h0000 : arr[a];
         e2 = (b == 4'd0) ? 16'h0000 : arr[b];
         rand_write(a, b);
         if (bypass_on() && wr_en && wr_reg == a && a != 4'd0) e1 = wr_data;
         if (bypass_on() && wr_en && wr_reg == b && b != 4'd0) e2 = wr_data;
         check("rnd_en1", 32'(ReadEnable1), 32'(exp_enable(a)));
         check("rnd_en2", 32'(ReadEnable2), 32'(exp_enable(b)));
         @(negedge clk);
         for (int h = 0; h < 8; h++) begin
            check("rnd_valid", 32'(rsp_valid), 32'd1);
            check("rnd_ready", 32'(req_ready), 32'd0);
            check("rnd_en_hold", 32'({ReadEnable1, ReadEnable2}), 32'd0);
            check("rnd_data1", 32'(rsp_data1), 32'(e1));
            check("rnd_data2", 32'(rsp_data2), 32'(e2));
            rdy = (h == 7) ? 1'b1 : 1'($urandom_range(0, 1));
            rsp_ready = rdy;
            rand_write(a, b);
            if (!rdy && bypass_on() && wr_en && wr_reg == a && a != 4'd0) e1 = wr_data;
            if (!rdy && bypass_on() && wr_en && wr_reg == b && b != 4'd0) e2 = wr_data;
            @(negedge clk);
            if (rdy) break;
         end
         rsp_ready = 1'b0;
         wr_en = 1'b0;
         check("rnd_done_valid", 32'(rsp_valid), 32'd0);
         check("rnd_done_ready", 32'(req_ready), 32'd1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

endmodule
